// File: rtl/booth_ctrl.sv
// Booth radix-2 multiplier sequencer: one-hot Moore control pulses c0..c6/fin for a 64-bit datapath.
// Latency: fin in cycle 133+k after LOAD_Q (k = ADD/SUB visits); bgn sampled only in IDLE.
// Backpressure: none; bgn is ignored while busy, so a new start must wait for IDLE.
module booth_ctrl (
    input  logic clk,
    input  logic rst_b,
    input  logic bgn,
    input  logic q0,
    input  logic q_m1,
    output logic c0,
    output logic c1,
    output logic c2,
    output logic c3,
    output logic c4,
    output logic c5,
    output logic c6,
    output logic busy,
    output logic fin
);

    typedef enum logic [3:0] {
        IDLE,
        LOAD_Q,
        LOAD_M,
        EVAL,
        ADD,
        SUB,
        SHIFT,
        OUT_A,
        OUT_Q,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [5:0] cnt;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // cnt holds the number of shifts already completed in this operation
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= 6'd0;
        end else if (state == LOAD_Q) begin
            cnt <= 6'd0;
        end else if (state == SHIFT) begin
            cnt <= cnt + 6'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bgn) state_nxt = LOAD_Q;
            LOAD_Q:  state_nxt = LOAD_M;
            LOAD_M:  state_nxt = EVAL;
            EVAL: begin
                case ({q0, q_m1})
                    2'b10:   state_nxt = SUB;
                    2'b01:   state_nxt = ADD;
                    default: state_nxt = SHIFT;
                endcase
            end
            ADD:     state_nxt = SHIFT;
            SUB:     state_nxt = SHIFT;
            SHIFT:   state_nxt = (cnt == 6'd63) ? OUT_A : EVAL;
            OUT_A:   state_nxt = OUT_Q;
            OUT_Q:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pure state decode keeps every output one-hot and free of input paths
    always_comb begin
        c0   = 1'b0;
        c1   = 1'b0;
        c2   = 1'b0;
        c3   = 1'b0;
        c4   = 1'b0;
        c5   = 1'b0;
        c6   = 1'b0;
        fin  = 1'b0;
        busy = (state != IDLE);
        case (state)
            LOAD_Q:  c0  = 1'b1;
            LOAD_M:  c1  = 1'b1;
            ADD:     c2  = 1'b1;
            SUB:     c3  = 1'b1;
            SHIFT:   c4  = 1'b1;
            OUT_A:   c5  = 1'b1;
            OUT_Q:   c6  = 1'b1;
            DONE:    fin = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl: per-cycle trace against a schedule model built from the operation rules,
// plus directed table rows, reset and bgn-while-busy sequences, and randomized back-to-back runs.
module tb_booth_ctrl;

    logic clk = 1'b0;
    logic rst_b;
    logic bgn;
    logic q0;
    logic q_m1;
    logic c0, c1, c2, c3, c4, c5, c6, busy, fin;
    logic [8:0] ov;

    assign ov = {busy, fin, c6, c5, c4, c3, c2, c1, c0};

    booth_ctrl dut (
        .clk  (clk),
        .rst_b(rst_b),
        .bgn  (bgn),
        .q0   (q0),
        .q_m1 (q_m1),
        .c0   (c0),
        .c1   (c1),
        .c2   (c2),
        .c3   (c3),
        .c4   (c4),
        .c5   (c5),
        .c6   (c6),
        .busy (busy),
        .fin  (fin)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // qv[t] = {q0,q_m1} presented during cycle t of an operation (LOAD_Q = cycle 1)
    logic [1:0] qv    [0:255];
    logic [8:0] exp_o [0:255];
    int exp_t, exp_k2, exp_k3;
    int last_fin, last_n2, last_n3, last_n4, last_nfin;
    bit busy_bgn;

    localparam logic [8:0] O_BUSY = 9'h100;

    typedef struct {
        logic q0;
        logic q_m1;
        int   fin_cyc;
        int   n2;
        int   n3;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected output per cycle: c0, c1, then 64 rounds of (decide, optional add/sub, shift), then A, Q, done
    task automatic build_model();
        int t;
        logic [1:0] b;
        for (int i = 0; i < 256; i++) exp_o[i] = 9'h000;
        exp_k2 = 0;
        exp_k3 = 0;
        exp_o[1] = O_BUSY | 9'h001;
        exp_o[2] = O_BUSY | 9'h002;
        t = 3;
        for (int i = 0; i < 64; i++) begin
            exp_o[t] = O_BUSY;
            b = qv[t];
            t++;
            if (b == 2'b10) begin
                exp_o[t] = O_BUSY | 9'h008;
                exp_k3++;
                t++;
            end else if (b == 2'b01) begin
                exp_o[t] = O_BUSY | 9'h004;
                exp_k2++;
                t++;
            end
            exp_o[t] = O_BUSY | 9'h010;
            t++;
        end
        exp_o[t]     = O_BUSY | 9'h020;
        exp_o[t + 1] = O_BUSY | 9'h040;
        exp_o[t + 2] = O_BUSY | 9'h080;
        exp_t = t + 2;
    endtask

    // Starts from an IDLE cycle and returns in the IDLE cycle following DONE
    task automatic run_op(input string tag);
        build_model();
        bgn = 1'b1;
        {q0, q_m1} = qv[0];
        step();
        last_fin = 0;
        last_n2 = 0;
        last_n3 = 0;
        last_n4 = 0;
        last_nfin = 0;
        for (int t = 1; t <= exp_t + 1; t++) begin
            check($sformatf("%s_trace_cyc%0d", tag, t), 32'(ov), 32'(exp_o[t]));
            if (c2) last_n2++;
            if (c3) last_n3++;
            if (c4) last_n4++;
            if (fin) begin
                last_nfin++;
                if (last_fin == 0) last_fin = t;
            end
            bgn = busy_bgn && (t == 5 || t == 50 || t == exp_t);
            {q0, q_m1} = qv[t];
            if (t <= exp_t) step();
        end
        bgn = 1'b0;
        check({tag, "_fin_cycle"}, last_fin, exp_t);
        check({tag, "_fin_count"}, last_nfin, 1);
        check({tag, "_c4_count"}, last_n4, 64);
        check({tag, "_c2_count"}, last_n2, exp_k2);
        check({tag, "_c3_count"}, last_n3, exp_k3);
    endtask

    task automatic fill_const(input logic [1:0] v);
        for (int i = 0; i < 256; i++) qv[i] = v;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{q0: 1'b0, q_m1: 1'b0, fin_cyc: 133, n2: 0,  n3: 0};
        vecs[1] = '{q0: 1'b1, q_m1: 1'b1, fin_cyc: 133, n2: 0,  n3: 0};
        vecs[2] = '{q0: 1'b1, q_m1: 1'b0, fin_cyc: 197, n2: 0,  n3: 64};
        vecs[3] = '{q0: 1'b0, q_m1: 1'b1, fin_cyc: 197, n2: 64, n3: 0};

        rst_b = 1'b0;
        bgn = 1'b0;
        q0 = 1'b0;
        q_m1 = 1'b0;
        busy_bgn = 1'b0;
        #3;
        check("reset_outputs", 32'(ov), 32'h0);
        bgn = 1'b1;
        step();
        step();
        check("reset_hold_with_bgn", 32'(ov), 32'h0);

        // Release with bgn already high: the first edge must start the operation
        @(negedge clk);
        rst_b = 1'b1;
        fill_const(2'b00);
        run_op("first_after_reset");

        foreach (vecs[i]) begin
            fill_const({vecs[i].q0, vecs[i].q_m1});
            run_op($sformatf("vec%0d", i));
            check($sformatf("vec%0d_table_fin", i), last_fin, vecs[i].fin_cyc);
            check($sformatf("vec%0d_table_c2", i), last_n2, vecs[i].n2);
            check($sformatf("vec%0d_table_c3", i), last_n3, vecs[i].n3);
        end

        // Reset asserted between edges during the 20th shift
        fill_const(2'b00);
        bgn = 1'b1;
        step();
        bgn = 1'b0;
        last_n4 = 0;
        for (int i = 0; i < 200 && last_n4 < 20; i++) begin
            if (c4) last_n4++;
            if (last_n4 < 20) step();
        end
        check("mid_run_reached_shift20", last_n4, 20);
        #2;
        rst_b = 1'b0;
        #1;
        check("mid_run_async_reset_outputs", 32'(ov), 32'h0);
        bgn = 1'b1;
        step();
        check("mid_run_held_in_reset", 32'(ov), 32'h0);
        @(negedge clk);
        rst_b = 1'b1;
        bgn = 1'b0;
        step();
        step();
        check("idle_after_reset_release", 32'(ov), 32'h0);
        run_op("after_mid_reset");
        check("after_mid_reset_full_length", last_fin, 133);

        busy_bgn = 1'b1;
        for (int i = 0; i < 256; i++) qv[i] = 2'($urandom_range(0, 3));
        run_op("bgn_while_busy");
        busy_bgn = 1'b0;
        step();
        check("idle_after_done_bgn", 32'(ov), 32'h0);

        for (int op = 0; op < 20; op++) begin
            for (int i = 0; i < 256; i++) qv[i] = 2'($urandom_range(0, 3));
            run_op($sformatf("rand%0d", op));
            check($sformatf("rand%0d_latency", op), last_fin, 133 + exp_k2 + exp_k3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
